// File: rtl/sparse_row_scheduler_pkg.sv
// rtl/sparse_row_scheduler_pkg.sv - shared widths, types and helpers for the sparse row scheduler
package sparse_row_scheduler_pkg;

  localparam int VAL_W  = 8;
  localparam int IDX_W  = 2;
  localparam int LANES  = 4;
  localparam int PSUM_W = 20;
  // The accumulator must be at least as wide as one PE partial sum.
  localparam int ACC_W  = 32;

  typedef logic signed [VAL_W-1:0] act_elem_t;
  typedef act_elem_t [LANES-1:0] activation_vec_t;

  // Two non-zero weights out of a group of four, each with its lane index.
  typedef struct packed {
    logic signed [VAL_W-1:0] val_1;
    logic [IDX_W-1:0]        idx_1;
    logic signed [VAL_W-1:0] val_0;
    logic [IDX_W-1:0]        idx_0;
  } sparse_packet_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT,
    S_DONE
  } sched_state_t;

  // Sign-extend a PE partial sum to accumulator width.
  function automatic logic signed [ACC_W-1:0] psum_sext(input logic signed [PSUM_W-1:0] p);
    return ACC_W'(p);
  endfunction

endpackage

// File: rtl/sparse_row_scheduler_if.sv
// rtl/sparse_row_scheduler_if.sv - buffer read ports, PE feed and row result stream
interface sparse_row_scheduler_if #(
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 10
);
  import sparse_row_scheduler_pkg::*;

  logic                     w_rd_en;
  logic [ADDR_W-1:0]        w_rd_addr;
  sparse_packet_t           w_rd_data;
  logic                     act_rd_en;
  logic [ADDR_W-1:0]        act_rd_addr;
  activation_vec_t          act_rd_data;
  logic                     pe_en;
  sparse_packet_t           pe_w;
  activation_vec_t          pe_act;
  logic signed [PSUM_W-1:0] pe_psum;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [ROW_W-1:0]         out_row;

  modport master (
    output w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
    output pe_en, pe_w, pe_act,
    output out_valid, out_data, out_row,
    input  w_rd_data, act_rd_data, pe_psum, out_ready
  );

  modport slave (
    input  w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
    input  pe_en, pe_w, pe_act,
    input  out_valid, out_data, out_row,
    output w_rd_data, act_rd_data, pe_psum, out_ready
  );

endinterface

// File: rtl/sparse_psum_acc.sv
// rtl/sparse_psum_acc.sv - two-stage valid/first tag pipeline and row accumulator
module sparse_psum_acc
  import sparse_row_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_abort,
  input  logic                     i_rd_strobe,
  input  logic                     i_first,
  input  logic signed [PSUM_W-1:0] i_psum,
  output logic                     o_v1,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic r_v1;
  logic r_v1_first;
  logic r_v2;
  logic r_v2_first;
  logic signed [ACC_W-1:0] r_acc;

  // Track which cycles carry PE input (v1) and PE output (v2); abort drops in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1       <= 1'b0;
      r_v1_first <= 1'b0;
      r_v2       <= 1'b0;
      r_v2_first <= 1'b0;
    end else if (i_abort) begin
      r_v1       <= 1'b0;
      r_v1_first <= 1'b0;
      r_v2       <= 1'b0;
      r_v2_first <= 1'b0;
    end else begin
      r_v1       <= i_rd_strobe;
      r_v1_first <= i_rd_strobe & i_first;
      r_v2       <= r_v1;
      r_v2_first <= r_v1_first;
    end
  end

  // Accumulate valid partial sums; the first packet of a row restarts the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_abort) begin
      r_acc <= '0;
    end else if (r_v2) begin
      if (r_v2_first) begin
        r_acc <= psum_sext(i_psum);
      end else begin
        r_acc <= r_acc + psum_sext(i_psum);
      end
    end
  end

  assign o_v1  = r_v1;
  assign o_acc = r_acc;

endmodule

// File: rtl/sparse_row_scheduler.sv
// rtl/sparse_row_scheduler.sv - row-at-a-time sequencer feeding one sparse PE
module sparse_row_scheduler
  import sparse_row_scheduler_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 10,
  parameter int PKT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [ROW_W-1:0]       i_cfg_rows,
  input  logic [PKT_W-1:0]       i_cfg_pkts,
  input  logic [ADDR_W-1:0]      i_cfg_w_base,
  input  logic [ADDR_W-1:0]      i_cfg_a_base,
  sparse_row_scheduler_if.master bus,
  output logic                   o_busy,
  output logic                   o_done
);

  sched_state_t r_state;
  sched_state_t w_state_next;

  logic [ROW_W-1:0]  r_rows;
  logic [PKT_W-1:0]  r_pkts;
  logic [ADDR_W-1:0] r_a_base;
  logic [ADDR_W-1:0] r_w_addr;
  logic [ROW_W-1:0]  r_row;
  logic [PKT_W-1:0]  r_pkt;
  logic              r_drain;

  logic                    w_rd_en;
  logic                    w_first;
  logic                    w_last_pkt;
  logic                    w_last_row;
  logic                    w_pkts_zero;
  logic                    w_v1;
  logic signed [ACC_W-1:0] w_acc;

  assign w_last_pkt  = (r_pkt == r_pkts - PKT_W'(1));
  assign w_last_row  = (r_row == r_rows - ROW_W'(1));
  assign w_pkts_zero = (r_pkts == '0);
  assign w_first     = w_rd_en && (r_pkt == '0);

  sparse_psum_acc u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_abort     (i_abort),
    .i_rd_strobe (w_rd_en),
    .i_first     (w_first),
    .i_psum      (bus.pe_psum),
    .o_v1        (w_v1),
    .o_acc       (w_acc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; abort overrides everything.
  always_comb begin
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_cfg_rows == '0) begin
              w_state_next = S_DONE;
            end else if (i_cfg_pkts == '0) begin
              w_state_next = S_OUT;
            end else begin
              w_state_next = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_last_pkt) begin
            w_state_next = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            w_state_next = S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (w_last_row) begin
              w_state_next = S_DONE;
            end else if (w_pkts_zero) begin
              w_state_next = S_OUT;
            end else begin
              w_state_next = S_RUN;
            end
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Output decode; everything not owned by the current state is forced to zero.
  always_comb begin
    w_rd_en         = (r_state == S_RUN);
    bus.w_rd_en     = w_rd_en;
    bus.act_rd_en   = w_rd_en;
    bus.w_rd_addr   = w_rd_en ? r_w_addr : '0;
    bus.act_rd_addr = w_rd_en ? (r_a_base + ADDR_W'(r_pkt)) : '0;
    bus.pe_en       = w_v1;
    bus.pe_w        = w_v1 ? bus.w_rd_data : '0;
    bus.pe_act      = w_v1 ? bus.act_rd_data : '0;
    bus.out_valid   = (r_state == S_OUT);
    bus.out_data    = ((r_state == S_OUT) && !w_pkts_zero) ? w_acc : '0;
    bus.out_row     = (r_state == S_OUT) ? r_row : '0;
    o_busy          = (r_state != S_IDLE);
    o_done          = (r_state == S_DONE);
  end

  // Job configuration, packet/row counters and the running weight address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows   <= '0;
      r_pkts   <= '0;
      r_a_base <= '0;
      r_w_addr <= '0;
      r_row    <= '0;
      r_pkt    <= '0;
      r_drain  <= 1'b0;
    end else if (i_abort) begin
      r_row   <= '0;
      r_pkt   <= '0;
      r_drain <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rows   <= i_cfg_rows;
            r_pkts   <= i_cfg_pkts;
            r_a_base <= i_cfg_a_base;
            r_w_addr <= i_cfg_w_base;
            r_row    <= '0;
            r_pkt    <= '0;
            r_drain  <= 1'b0;
          end
        end
        S_RUN: begin
          r_w_addr <= r_w_addr + ADDR_W'(1);
          r_pkt    <= w_last_pkt ? '0 : (r_pkt + PKT_W'(1));
        end
        S_DRAIN: begin
          r_drain <= ~r_drain;
        end
        S_OUT: begin
          if (bus.out_ready && !w_last_row) begin
            r_row <= r_row + ROW_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_row_scheduler.sv
// tb/tb_sparse_row_scheduler.sv - self-checking bench for sparse_row_scheduler
module tb_sparse_row_scheduler;
  import sparse_row_scheduler_pkg::*;

  localparam int ADDR_W = 12;
  localparam int ROW_W  = 10;
  localparam int PKT_W  = 8;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ROW_W-1:0]  cfg_rows = '0;
  logic [PKT_W-1:0]  cfg_pkts = '0;
  logic [ADDR_W-1:0] cfg_w_base = '0;
  logic [ADDR_W-1:0] cfg_a_base = '0;
  logic              busy;
  logic              done;

  int total = 0;
  int bad = 0;

  sparse_row_scheduler_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bus ();

  sparse_row_scheduler #(.ADDR_W(ADDR_W), .ROW_W(ROW_W), .PKT_W(PKT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_cfg_rows   (cfg_rows),
    .i_cfg_pkts   (cfg_pkts),
    .i_cfg_w_base (cfg_w_base),
    .i_cfg_a_base (cfg_a_base),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  sparse_packet_t  wmem [DEPTH];
  activation_vec_t amem [DEPTH];

  function automatic logic signed [PSUM_W-1:0] pe_calc(input sparse_packet_t p, input activation_vec_t a);
    int s;
    s = int'(p.val_0) * int'(a[p.idx_0]) + int'(p.val_1) * int'(a[p.idx_1]);
    return PSUM_W'(s);
  endfunction

  // Buffers with one-cycle read latency and a PE with one-cycle latency.
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_rd_data <= wmem[bus.w_rd_addr];
    if (bus.act_rd_en) bus.act_rd_data <= amem[bus.act_rd_addr];
    if (bus.pe_en) bus.pe_psum <= pe_calc(bus.pe_w, bus.pe_act);
  end

  // Reference: row r is the wrapped sum of P packet dot products.
  function automatic logic signed [31:0] ref_row(input int r, input int p, input logic [11:0] wb, input logic [11:0] ab);
    logic signed [31:0] acc;
    acc = 0;
    for (int c = 0; c < p; c++) begin
      acc = acc + 32'(pe_calc(wmem[(int'(wb) + r * p + c) % DEPTH], amem[(int'(ab) + c) % DEPTH]));
    end
    return acc;
  endfunction

  logic signed [31:0] res_data[$];
  int                 res_row[$];
  int                 hs_cyc[$];
  logic [11:0]        rd_addrs[$];
  int                 first_valid;
  int                 done_cyc;
  int                 n_reads;
  int                 reads_in_out;
  int                 stab_viol;
  bit                 timed_out;

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      wmem[i] = 20'($urandom);
      amem[i] = $urandom;
    end
  endtask

  // Runs one job from the current cycle, recording what the DUT shows each cycle.
  task automatic run_job(input int rows, input int pkts, input logic [11:0] wb, input logic [11:0] ab,
                         input int stall0, input bit rand_rdy, input int abort_at, input int busy_start_at);
    logic signed [31:0] pd;
    int pr;
    bit pv;
    int stall_left;
    res_data.delete(); res_row.delete(); hs_cyc.delete(); rd_addrs.delete();
    first_valid = -1; done_cyc = -1; n_reads = 0; reads_in_out = 0; stab_viol = 0; timed_out = 0;
    pv = 0; pd = 0; pr = 0; stall_left = stall0;
    cfg_rows = ROW_W'(rows); cfg_pkts = PKT_W'(pkts); cfg_w_base = wb; cfg_a_base = ab;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      abort = (k == abort_at);
      start = (k == busy_start_at);
      if (k == busy_start_at) begin
        cfg_rows = ROW_W'($urandom_range(1, 5)); cfg_pkts = PKT_W'($urandom_range(1, 9));
        cfg_w_base = 12'($urandom); cfg_a_base = 12'($urandom);
      end
      if (bus.out_valid && stall_left > 0) begin
        bus.out_ready = 1'b0; stall_left--;
      end else begin
        bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (bus.w_rd_en) begin
        n_reads++; rd_addrs.push_back(bus.w_rd_addr);
        if (bus.out_valid) reads_in_out++;
      end
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = k;
        if (pv && (bus.out_data !== pd || int'(bus.out_row) !== pr)) stab_viol++;
        pv = !bus.out_ready; pd = bus.out_data; pr = int'(bus.out_row);
        if (bus.out_ready) begin
          res_data.push_back(bus.out_data); res_row.push_back(int'(bus.out_row)); hs_cyc.push_back(k);
        end
      end else begin
        pv = 0;
      end
      if (done) done_cyc = k;
      @(posedge clk); #1;
      if (k == abort_at) begin
        abort = 1'b0; return;
      end
      if (done_cyc >= 0) begin
        start = 1'b0; return;
      end
    end
    start = 1'b0;
    timed_out = 1;
  endtask

  task automatic test_reset();
    logic [123:0] outs;
    outs = {busy, done, bus.w_rd_en, bus.act_rd_en, bus.pe_en, bus.out_valid, bus.w_rd_addr,
            bus.act_rd_addr, bus.out_data, bus.out_row, bus.pe_w, bus.pe_act};
    total++; if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    outs = {busy, done, bus.w_rd_en, bus.act_rd_en, bus.pe_en, bus.out_valid, bus.w_rd_addr,
            bus.act_rd_addr, bus.out_data, bus.out_row, bus.pe_w, bus.pe_act};
    total++; if (outs !== '0) begin bad++; $display("FAIL idle_outputs got=%h exp=0", outs); end
  endtask

  task automatic test_single_packet();
    sparse_packet_t p;
    activation_vec_t a;
    p.val_0 = 8'sd3; p.idx_0 = 2'd0; p.val_1 = -8'sd2; p.idx_1 = 2'd3;
    a[0] = 8'sd10; a[1] = 8'sd0; a[2] = 8'sd0; a[3] = 8'sd5;
    wmem[100] = p; amem[200] = a;
    run_job(1, 1, 12'd100, 12'd200, 0, 0, -1, -1);
    total++; if (timed_out) begin bad++; $display("FAIL single_timeout got=1 exp=0"); end
    total++; if (res_data.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", res_data.size()); end
    else begin
      total++; if (res_data[0] !== 32'sd20) begin bad++; $display("FAIL single_data got=%0d exp=20", res_data[0]); end
      total++; if (res_row[0] !== 0) begin bad++; $display("FAIL single_row got=%0d exp=0", res_row[0]); end
      total++; if (done_cyc !== hs_cyc[0] + 1) begin bad++; $display("FAIL single_done_cyc got=%0d exp=%0d", done_cyc, hs_cyc[0] + 1); end
    end
    total++; if (first_valid !== 3) begin bad++; $display("FAIL single_valid_cyc got=%0d exp=3", first_valid); end
    total++; if (n_reads !== 1) begin bad++; $display("FAIL single_reads got=%0d exp=1", n_reads); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_after got=%0d exp=0", busy); end
  endtask

  task automatic test_sign_extension();
    sparse_packet_t p;
    activation_vec_t a;
    p.val_0 = 8'sd127; p.idx_0 = 2'd0; p.val_1 = 8'sd127; p.idx_1 = 2'd1;
    for (int i = 0; i < 4; i++) a[i] = -8'sd128;
    for (int i = 0; i < 4; i++) begin wmem[300 + i] = p; amem[400 + i] = a; end
    run_job(1, 4, 12'd300, 12'd400, 0, 1, -1, -1);
    total++; if (res_data.size() != 1 || timed_out) begin bad++; $display("FAIL signext_count got=%0d exp=1", res_data.size()); end
    else begin
      total++; if (res_data[0] !== -32'sd130048) begin bad++; $display("FAIL signext_data got=%0d exp=-130048", res_data[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] wb;
    logic [11:0] ab;
    logic [11:0] ea;
    int seq_bad;
    fill_random();
    wb = 12'($urandom); ab = 12'($urandom);
    run_job(2, 3, wb, ab, 5, 0, -1, -1);
    total++; if (res_data.size() != 2 || timed_out) begin bad++; $display("FAIL bp_count got=%0d exp=2", res_data.size()); end
    else begin
      for (int r = 0; r < 2; r++) begin
        total++; if (res_data[r] !== ref_row(r, 3, wb, ab)) begin bad++; $display("FAIL bp_data%0d got=%0d exp=%0d", r, res_data[r], ref_row(r, 3, wb, ab)); end
        total++; if (res_row[r] !== r) begin bad++; $display("FAIL bp_row%0d got=%0d exp=%0d", r, res_row[r], r); end
      end
      total++; if (hs_cyc[0] !== first_valid + 5) begin bad++; $display("FAIL bp_hs_cyc got=%0d exp=%0d", hs_cyc[0], first_valid + 5); end
    end
    total++; if (stab_viol !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_viol); end
    total++; if (reads_in_out !== 0) begin bad++; $display("FAIL bp_reads_in_out got=%0d exp=0", reads_in_out); end
    total++; if (rd_addrs.size() != 6) begin bad++; $display("FAIL bp_nreads got=%0d exp=6", rd_addrs.size()); end
    else begin
      ea = wb + 12'd3;
      total++; if (rd_addrs[3] !== ea) begin bad++; $display("FAIL bp_row1_addr got=%0d exp=%0d", rd_addrs[3], ea); end
      seq_bad = 0;
      for (int i = 0; i < 6; i++) if (rd_addrs[i] !== 12'(wb + 12'(i))) seq_bad++;
      total++; if (seq_bad !== 0) begin bad++; $display("FAIL bp_addr_seq got=%0d exp=0", seq_bad); end
    end
  endtask

  task automatic test_degenerate();
    run_job(0, 3, 12'd10, 12'd20, 0, 0, -1, -1);
    total++; if (done_cyc !== 0) begin bad++; $display("FAIL rows0_done_cyc got=%0d exp=0", done_cyc); end
    total++; if (n_reads !== 0) begin bad++; $display("FAIL rows0_reads got=%0d exp=0", n_reads); end
    total++; if (res_data.size() != 0) begin bad++; $display("FAIL rows0_results got=%0d exp=0", res_data.size()); end
    run_job(2, 0, 12'd10, 12'd20, 0, 1, -1, -1);
    total++; if (res_data.size() != 2 || timed_out) begin bad++; $display("FAIL pkts0_count got=%0d exp=2", res_data.size()); end
    else begin
      for (int r = 0; r < 2; r++) begin
        total++; if (res_data[r] !== 0) begin bad++; $display("FAIL pkts0_data%0d got=%0d exp=0", r, res_data[r]); end
        total++; if (res_row[r] !== r) begin bad++; $display("FAIL pkts0_row%0d got=%0d exp=%0d", r, res_row[r], r); end
      end
    end
    total++; if (n_reads !== 0) begin bad++; $display("FAIL pkts0_reads got=%0d exp=0", n_reads); end
  endtask

  task automatic test_abort();
    logic [11:0] wb;
    logic [11:0] ab;
    fill_random();
    run_job(2, 4, 12'($urandom), 12'($urandom), 0, 0, 1, -1);
    total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0d exp=0", busy | bus.out_valid); end
    total++; if (bus.pe_en !== 1'b0) begin bad++; $display("FAIL abort_pe_en got=%0d exp=0", bus.pe_en); end
    total++; if (done_cyc !== -1) begin bad++; $display("FAIL abort_no_done got=%0d exp=-1", done_cyc); end
    wb = 12'($urandom); ab = 12'($urandom);
    run_job(1, 3, wb, ab, 0, 0, -1, -1);
    total++; if (res_data.size() != 1 || timed_out) begin bad++; $display("FAIL abort_fresh_count got=%0d exp=1", res_data.size()); end
    else begin
      total++; if (res_data[0] !== ref_row(0, 3, wb, ab)) begin bad++; $display("FAIL abort_fresh_data got=%0d exp=%0d", res_data[0], ref_row(0, 3, wb, ab)); end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [123:0] outs;
    cfg_rows = 10'd1; cfg_pkts = 8'd3; cfg_w_base = 12'd50; cfg_a_base = 12'd60;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (bus.pe_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL drain_active got=%0d exp=1", bus.pe_en & busy); end
    rst_n = 1'b0;
    #1;
    outs = {busy, done, bus.w_rd_en, bus.act_rd_en, bus.pe_en, bus.out_valid, bus.w_rd_addr,
            bus.act_rd_addr, bus.out_data, bus.out_row, bus.pe_w, bus.pe_act};
    total++; if (outs !== '0) begin bad++; $display("FAIL drain_reset_outputs got=%h exp=0", outs); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_reset_stays_idle got=%0d exp=0", busy | bus.out_valid); end
  endtask

  task automatic test_start_while_busy();
    logic [11:0] wb;
    logic [11:0] ab;
    fill_random();
    wb = 12'($urandom); ab = 12'($urandom);
    run_job(2, 3, wb, ab, 0, 1, -1, 1);
    total++; if (res_data.size() != 2 || timed_out) begin bad++; $display("FAIL busy_start_count got=%0d exp=2", res_data.size()); end
    else begin
      for (int r = 0; r < 2; r++) begin
        total++; if (res_data[r] !== ref_row(r, 3, wb, ab)) begin bad++; $display("FAIL busy_start_data%0d got=%0d exp=%0d", r, res_data[r], ref_row(r, 3, wb, ab)); end
      end
    end
    total++; if (n_reads !== 6) begin bad++; $display("FAIL busy_start_reads got=%0d exp=6", n_reads); end
  endtask

  task automatic test_random_jobs();
    int rows;
    int pkts;
    logic [11:0] wb;
    logic [11:0] ab;
    for (int j = 0; j < 8; j++) begin
      fill_random();
      rows = $urandom_range(1, 4); pkts = $urandom_range(1, 8);
      wb = 12'($urandom); ab = 12'($urandom);
      run_job(rows, pkts, wb, ab, 0, 1, -1, -1);
      total++; if (res_data.size() != rows || timed_out) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", j, res_data.size(), rows); end
      else begin
        for (int r = 0; r < rows; r++) begin
          total++; if (res_data[r] !== ref_row(r, pkts, wb, ab) || res_row[r] !== r) begin
            bad++; $display("FAIL rand%0d_row%0d got=%0d/%0d exp=%0d/%0d", j, r, res_data[r], res_row[r], ref_row(r, pkts, wb, ab), r);
          end
        end
      end
      total++; if (n_reads !== rows * pkts || reads_in_out !== 0) begin bad++; $display("FAIL rand%0d_reads got=%0d exp=%0d", j, n_reads, rows * pkts); end
      total++; if (stab_viol !== 0) begin bad++; $display("FAIL rand%0d_stable got=%0d exp=0", j, stab_viol); end
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_packet();
    test_sign_extension();
    test_backpressure();
    test_degenerate();
    test_abort();
    test_reset_mid_drain();
    test_start_while_busy();
    test_random_jobs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sparse_row_scheduler.md
# sparse_row_scheduler

Sequencer that drives one `sparse_processing` PE through a sparse matrix-vector job, one output row at a time. It streams compressed weight packets and matching activation groups from two 1-cycle-latency read ports, feeds the PE, and accumulates the per-packet PE partial sums into a full-width row result. Each result is emitted on a valid/ready output. It sits between the job-control registers, the weight and activation buffers, and the PE.

## Interface
- `ADDR_W`, 12: weight/activation buffer address width.
- `ROW_W`, 10: row-count width.
- `PKT_W`, 8: packets-per-row count width.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: job start pulse; ignored unless in IDLE.
- `abort`  in  1: synchronous job abort.
- `cfg_rows`  in  ROW_W: number of rows; latched on start.
- `cfg_pkts`  in  PKT_W: packets per row (K/4); latched on start.
- `cfg_w_base`  in  ADDR_W: weight base address; latched on start.
- `cfg_a_base`  in  ADDR_W: activation base address; latched on start.
- `w_rd_en`  out  1: weight read strobe.
- `w_rd_addr`  out  ADDR_W: weight read address.
- `w_rd_data`  in  sparse_packet_t: weight packet, valid the cycle after `w_rd_en`.
- `act_rd_en`  out  1: activation read strobe, equal to `w_rd_en`.
- `act_rd_addr`  out  ADDR_W: activation group address.
- `act_rd_data`  in  activation_vec_t: activation group, valid the cycle after `act_rd_en`.
- `pe_en`  out  1: PE enable.
- `pe_w`  out  sparse_packet_t: PE weight packet, combinational from `w_rd_data`.
- `pe_act`  out  activation_vec_t: PE activation vector, combinational from `act_rd_data`.
- `pe_psum`  in  signed PSUM_W: PE `psum_out`.
- `out_valid`  out  1: row result valid.
- `out_ready`  in  1: consumer ready.
- `out_data`  out  signed ACC_W: row result.
- `out_row`  out  ROW_W: index of the row in `out_data`.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: single-cycle pulse at job completion.

## Operation
- FSM states: IDLE, RUN, DRAIN, OUT, DONE.
- IDLE → RUN on `start`. If `cfg_rows==0`, IDLE → DONE instead. If `cfg_pkts==0`, IDLE → OUT instead.
- RUN, packet counter c = 0..P-1, one packet per cycle:
  - `w_rd_en = act_rd_en = 1`.
  - `w_rd_addr = cfg_w_base + row*P + c`, implemented as a running counter.
  - `act_rd_addr = cfg_a_base + c`.
  - After c = P-1, go to DRAIN.
- Two-stage valid pipeline:
  - v1 = registered read strobe; `pe_en = v1`.
  - v2 = registered v1; when v2 is set, `pe_psum` is valid.
  - Each stage carries a `first` tag.
- Accumulate when v2 is set:
  - `first` set: `acc <= sext(pe_psum)`.
  - otherwise: `acc <= acc + sext(pe_psum)`.
  - Two's-complement wrap at ACC_W; no saturation.
- DRAIN lasts exactly 2 cycles, then go to OUT.
- OUT:
  - `out_valid = 1`, `out_data = acc`, `out_row = row`. Both are held stable until the handshake.
  - When `cfg_pkts==0`, `out_data = 0`.
  - On `out_valid && out_ready`: if this was the last row, go to DONE; otherwise increment row and go to RUN (or OUT again when P==0).
- No reads are issued while in OUT. Backpressure therefore needs no skid buffer.
- DONE: `done = 1` for one cycle, then go to IDLE.
- `abort`, any state:
  - Next state is IDLE.
  - v1 and v2 are cleared, so in-flight psums are discarded.
  - `out_valid` drops and no `done` is generated.
- `start` while busy: ignored. Configuration is not re-latched.

## Timing
- Reset values: all outputs 0. The internal state is IDLE with acc, counters and v1/v2 cleared.
- Edge numbering: `start` is sampled on edge 0.
  - RUN cycle c lies between edge c and edge c+1.
  - Last accumulate is on edge P+2.
  - `out_valid` is first high after edge P+2.
- Row period = P + 2 + (handshake wait ≥ 1) cycles.
- `done` is high in the cycle after the final handshake edge.
- `cfg_rows==0`: `done` is high in the cycle after edge 0.
- Memory latency is fixed at 1 cycle.

## Structure
- Add to `sparse_pkg`:
  - `PSUM_W = 20`.
  - `ACC_W = 32`, with the constraint ACC_W ≥ PSUM_W.
  - `sched_state_t` enum.
- Reuse the existing `sparse_packet_t` and `activation_vec_t`.
- One sub-module: `sparse_psum_acc`, holding the v1/v2 tag pipeline and the accumulator register (clear-on-first, sign-extend, abort clear).
- The top-level wrapper instantiates `sparse_row_scheduler` next to the PE. The scheduler does not instantiate the PE.

## Test plan
- Single packet, rows=1, P=1:
  - Stimulus: packet `val_0=3, idx_0=0, val_1=-2, idx_1=3`; act = {10,0,0,5}.
  - Response: `out_data=20`, `out_row=0`; `out_valid` after edge 3; `done` after the handshake.
- Sign extension and accumulation, rows=1, P=4:
  - Stimulus: every packet uses vals 127/127 on acts -128/-128.
  - Response: `out_data=-130048`.
- Backpressure, rows=2, P=3:
  - Stimulus: `out_ready` held low for 5 cycles on row 0.
  - Response: `out_data`/`out_row` stable and zero reads issued during the wait; row 1 reads start at `w_rd_addr = base+3`.
- Degenerate configurations:
  - `cfg_rows=0`: `done` in the cycle after edge 0; no `w_rd_en`.
  - `cfg_pkts=0`, rows=2: two results of 0 (rows 0 and 1); no reads.
- Abort and reset mid-operation:
  - Stimulus: `abort` in RUN c=1, then a fresh job.
  - Response: the fresh job's result excludes stale psums. Asserting `rst_n` mid-DRAIN returns all outputs to 0 immediately.
- Start while busy:
  - Stimulus: `start` pulse with new cfg during RUN.
  - Response: ignored; the original job completes unchanged.
